generic_sram_byte_en_arbiter: RTL and testbench

- Two-initiator arbiter that shares one generic byte-enable SRAM port, e.g. an AXI4 SRAM bridge plus a DMA/backdoor initiator on one memory.
- Round-robin grant with a bounded lock for bursts.
- SRAM read latency is fixed at 1 cycle; the arbiter returns read data to the initiator that issued the read.

---
 rtl/generic_sram_byte_en_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_generic_sram_byte_en_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_sram_byte_en_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : generic_sram_byte_en_arbiter
// Purpose  : Two-initiator round-robin arbiter with bounded burst lock that
//            shares one byte-enable SRAM port (1-cycle read latency) and
//            routes read data back to the initiator that issued the read.
// Options  : GENERIC_SRAM_ARB_STATS_EN adds saturating grant/conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
module generic_sram_byte_en_arbiter #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int LOCK_MAX      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i0_req,
  input  logic                      i0_lock,
  output logic                      i0_gnt,
  input  logic [MEM_ADDR_BITS-1:0]  i0_addr,
  input  logic                      i0_write_en,
  input  logic [DATA_WIDTH/8-1:0]   i0_byte_en,
  input  logic [DATA_WIDTH-1:0]     i0_write_data,
  output logic [DATA_WIDTH-1:0]     i0_read_data,
  output logic                      i0_rvalid,
  input  logic                      i1_req,
  input  logic                      i1_lock,
  output logic                      i1_gnt,
  input  logic [MEM_ADDR_BITS-1:0]  i1_addr,
  input  logic                      i1_write_en,
  input  logic [DATA_WIDTH/8-1:0]   i1_byte_en,
  input  logic [DATA_WIDTH-1:0]     i1_write_data,
  output logic [DATA_WIDTH-1:0]     i1_read_data,
  output logic                      i1_rvalid,
  output logic [MEM_ADDR_BITS-1:0]  addr,
  output logic                      read_en,
  output logic                      write_en,
  output logic [DATA_WIDTH/8-1:0]   byte_en,
  output logic [DATA_WIDTH-1:0]     write_data,
  input  logic [DATA_WIDTH-1:0]     read_data
`ifdef GENERIC_SRAM_ARB_STATS_EN
  ,
  output logic [15:0]               i0_gnt_count,
  output logic [15:0]               i1_gnt_count,
  output logic [15:0]               conflict_count
`endif
);

  localparam int         BE_W         = DATA_WIDTH / 8;
  localparam logic [7:0] LOCK_MAX_CNT = 8'(LOCK_MAX);

  // Arbitration state
  logic                     last_gnt_q,   last_gnt_d;
  logic                     lock_valid_q, lock_valid_d;
  logic                     lock_owner_q, lock_owner_d;
  logic [7:0]               lock_cnt_q,   lock_cnt_d;
  // Read return tracking
  logic                     rd_pend_q,    rd_pend_d;
  logic                     rd_port_q,    rd_port_d;
  // Last granted payload, replayed on idle cycles
  logic [MEM_ADDR_BITS-1:0] addr_hold_q,  addr_hold_d;
  logic [BE_W-1:0]          be_hold_q,    be_hold_d;
  logic [DATA_WIDTH-1:0]    wd_hold_q,    wd_hold_d;

  // Grant decision
  logic                     gnt_any;
  logic                     gnt_sel;
  logic                     lock_hold;
  // Payload of the selected initiator
  logic [MEM_ADDR_BITS-1:0] sel_addr;
  logic                     sel_we;
  logic                     sel_lock;
  logic [BE_W-1:0]          sel_be;
  logic [DATA_WIDTH-1:0]    sel_wd;

  // Pick at most one initiator: live lock first, then single requester, then round-robin
  always_comb begin
    gnt_any   = 1'b0;
    gnt_sel   = 1'b0;
    lock_hold = lock_valid_q && (lock_cnt_q < LOCK_MAX_CNT) &&
                (lock_owner_q ? i1_req : i0_req);
    if (!rst_n) begin
      gnt_any = 1'b0;
    end else if (lock_hold) begin
      gnt_any = 1'b1;
      gnt_sel = lock_owner_q;
    end else if (i0_req && i1_req) begin
      gnt_any = 1'b1;
      gnt_sel = !last_gnt_q;
    end else if (i0_req) begin
      gnt_any = 1'b1;
      gnt_sel = 1'b0;
    end else if (i1_req) begin
      gnt_any = 1'b1;
      gnt_sel = 1'b1;
    end
  end

  // Route the selected initiator's payload
  always_comb begin
    sel_addr = gnt_sel ? i1_addr       : i0_addr;
    sel_we   = gnt_sel ? i1_write_en   : i0_write_en;
    sel_lock = gnt_sel ? i1_lock       : i0_lock;
    sel_be   = gnt_sel ? i1_byte_en    : i0_byte_en;
    sel_wd   = gnt_sel ? i1_write_data : i0_write_data;
  end

  // Drive the SRAM port and grant/return outputs
  always_comb begin
    i0_gnt       = gnt_any && !gnt_sel;
    i1_gnt       = gnt_any &&  gnt_sel;
    read_en      = gnt_any && !sel_we;
    write_en     = gnt_any &&  sel_we;
    addr         = '0;
    byte_en      = '0;
    write_data   = '0;
    if (rst_n) begin
      addr       = gnt_any ? sel_addr : addr_hold_q;
      byte_en    = gnt_any ? sel_be   : be_hold_q;
      write_data = gnt_any ? sel_wd   : wd_hold_q;
    end
    // Gating with rst_n drops a pending return as soon as reset is asserted
    i0_rvalid    = rst_n && rd_pend_q && !rd_port_q;
    i1_rvalid    = rst_n && rd_pend_q &&  rd_port_q;
    i0_read_data = i0_rvalid ? read_data : '0;
    i1_read_data = i1_rvalid ? read_data : '0;
  end

  // Next-state for round-robin pointer, lock tracking, read return and payload hold
  always_comb begin
    last_gnt_d   = last_gnt_q;
    lock_valid_d = 1'b0;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = '0;
    rd_pend_d    = 1'b0;
    rd_port_d    = rd_port_q;
    addr_hold_d  = addr_hold_q;
    be_hold_d    = be_hold_q;
    wd_hold_d    = wd_hold_q;
    if (gnt_any) begin
      last_gnt_d  = gnt_sel;
      rd_pend_d   = !sel_we;
      rd_port_d   = gnt_sel;
      addr_hold_d = sel_addr;
      be_hold_d   = sel_be;
      wd_hold_d   = sel_wd;
      if (sel_lock) begin
        lock_valid_d = 1'b1;
        lock_owner_d = gnt_sel;
        if (lock_valid_q && (lock_owner_q == gnt_sel)) begin
          lock_cnt_d = (lock_cnt_q >= LOCK_MAX_CNT) ? LOCK_MAX_CNT : lock_cnt_q + 8'd1;
        end else begin
          lock_cnt_d = 8'd1;
        end
      end
    end
  end

  // State register; last_gnt resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt_q   <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_port_q    <= 1'b0;
      addr_hold_q  <= '0;
      be_hold_q    <= '0;
      wd_hold_q    <= '0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_port_q    <= rd_port_d;
      addr_hold_q  <= addr_hold_d;
      be_hold_q    <= be_hold_d;
      wd_hold_q    <= wd_hold_d;
    end
  end

`ifdef GENERIC_SRAM_ARB_STATS_EN
  logic [15:0] i0_cnt_q,   i0_cnt_d;
  logic [15:0] i1_cnt_q,   i1_cnt_d;
  logic [15:0] conf_cnt_q, conf_cnt_d;

  // Saturating grant and conflict counters
  always_comb begin
    i0_cnt_d   = i0_cnt_q;
    i1_cnt_d   = i1_cnt_q;
    conf_cnt_d = conf_cnt_q;
    if (i0_gnt && (i0_cnt_q != 16'hFFFF)) i0_cnt_d = i0_cnt_q + 16'd1;
    if (i1_gnt && (i1_cnt_q != 16'hFFFF)) i1_cnt_d = i1_cnt_q + 16'd1;
    if (i0_req && i1_req && (conf_cnt_q != 16'hFFFF)) conf_cnt_d = conf_cnt_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i0_cnt_q   <= '0;
      i1_cnt_q   <= '0;
      conf_cnt_q <= '0;
    end else begin
      i0_cnt_q   <= i0_cnt_d;
      i1_cnt_q   <= i1_cnt_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign i0_gnt_count   = i0_cnt_q;
  assign i1_gnt_count   = i1_cnt_q;
  assign conflict_count = conf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_generic_sram_byte_en_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_generic_sram_byte_en_arbiter
// Purpose  : Self-checking bench: behavioural SRAM, cycle model of the
//            arbitration rules, and directed scenarios with literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_generic_sram_byte_en_arbiter;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int BW       = DW / 8;
  localparam int LOCK_MAX = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i0_req = 0, i0_lock = 0, i0_write_en = 0;
  logic [AW-1:0] i0_addr = '0;
  logic [BW-1:0] i0_byte_en = '0;
  logic [DW-1:0] i0_write_data = '0;
  logic          i1_req = 0, i1_lock = 0, i1_write_en = 0;
  logic [AW-1:0] i1_addr = '0;
  logic [BW-1:0] i1_byte_en = '0;
  logic [DW-1:0] i1_write_data = '0;
  logic          i0_gnt, i1_gnt, i0_rvalid, i1_rvalid;
  logic [DW-1:0] i0_read_data, i1_read_data;
  logic [AW-1:0] addr;
  logic          read_en, write_en;
  logic [BW-1:0] byte_en;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data = '0;
`ifdef GENERIC_SRAM_ARB_STATS_EN
  logic [15:0]   i0_gnt_count, i1_gnt_count, conflict_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial forever #5 clk = ~clk;

  generic_sram_byte_en_arbiter #(
    .MEM_ADDR_BITS(AW), .DATA_WIDTH(DW), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i0_req(i0_req), .i0_lock(i0_lock), .i0_gnt(i0_gnt), .i0_addr(i0_addr),
    .i0_write_en(i0_write_en), .i0_byte_en(i0_byte_en), .i0_write_data(i0_write_data),
    .i0_read_data(i0_read_data), .i0_rvalid(i0_rvalid),
    .i1_req(i1_req), .i1_lock(i1_lock), .i1_gnt(i1_gnt), .i1_addr(i1_addr),
    .i1_write_en(i1_write_en), .i1_byte_en(i1_byte_en), .i1_write_data(i1_write_data),
    .i1_read_data(i1_read_data), .i1_rvalid(i1_rvalid),
    .addr(addr), .read_en(read_en), .write_en(write_en), .byte_en(byte_en),
    .write_data(write_data), .read_data(read_data)
`ifdef GENERIC_SRAM_ARB_STATS_EN
    , .i0_gnt_count(i0_gnt_count), .i1_gnt_count(i1_gnt_count),
    .conflict_count(conflict_count)
`endif
  );

  // Behavioural SRAM: byte-masked write, registered read
  logic [DW-1:0] sram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) sram[i] = '0;
  always @(posedge clk) begin
    if (write_en)
      for (int b = 0; b < BW; b++)
        if (byte_en[b]) sram[addr][8*b +: 8] <= write_data[8*b +: 8];
    if (read_en) read_data <= sram[addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state below is the value the registers take after the coming edge
  logic [DW-1:0] mmem [0:(1<<AW)-1];
  initial begin : model
    int            last, owner, cnt, g, pport;
    logic          pend;
    logic [DW-1:0] pdata, h_wd, g_wd;
    logic [AW-1:0] h_addr, g_addr;
    logic [BW-1:0] h_be, g_be;
    logic          g_we, g_lock;
    logic [1:0]    r;
    int            sc0, sc1, scf;
    for (int i = 0; i < (1<<AW); i++) mmem[i] = '0;
    last = 1; owner = -1; cnt = 0; pend = 0; pport = 0; pdata = '0;
    h_addr = '0; h_be = '0; h_wd = '0; sc0 = 0; sc1 = 0; scf = 0;
    forever begin
      @(negedge clk);
`ifdef GENERIC_SRAM_ARB_STATS_EN
      chk("m_i0_gnt_count", i0_gnt_count, 64'(sc0));
      chk("m_i1_gnt_count", i1_gnt_count, 64'(sc1));
      chk("m_conflict_count", conflict_count, 64'(scf));
`endif
      if (!rst_n) begin
        chk("m_rst_gnt", {i0_gnt, i1_gnt}, 2'b00);
        chk("m_rst_strobes", {read_en, write_en}, 2'b00);
        chk("m_rst_addr", addr, 0);
        chk("m_rst_byte_en", byte_en, 0);
        chk("m_rst_rvalid", {i0_rvalid, i1_rvalid}, 2'b00);
        chk("m_rst_rdata", {i0_read_data, i1_read_data}, 0);
        last = 1; owner = -1; cnt = 0; pend = 0;
        h_addr = '0; h_be = '0; h_wd = '0; sc0 = 0; sc1 = 0; scf = 0;
      end else begin
        r = {i1_req, i0_req};
        if (owner >= 0 && r[owner] && cnt < LOCK_MAX) g = owner;
        else if (r == 2'b01) g = 0;
        else if (r == 2'b10) g = 1;
        else if (r == 2'b11) g = 1 - last;
        else g = -1;
        g_addr = (g == 1) ? i1_addr : i0_addr;
        g_we   = (g == 1) ? i1_write_en : i0_write_en;
        g_lock = (g == 1) ? i1_lock : i0_lock;
        g_be   = (g == 1) ? i1_byte_en : i0_byte_en;
        g_wd   = (g == 1) ? i1_write_data : i0_write_data;
        chk("m_i0_gnt", i0_gnt, g == 0);
        chk("m_i1_gnt", i1_gnt, g == 1);
        chk("m_write_en", write_en, g >= 0 && g_we);
        chk("m_read_en", read_en, g >= 0 && !g_we);
        chk("m_addr", addr, (g >= 0) ? g_addr : h_addr);
        chk("m_byte_en", byte_en, (g >= 0) ? g_be : h_be);
        chk("m_write_data", write_data, (g >= 0) ? g_wd : h_wd);
        chk("m_i0_rvalid", i0_rvalid, pend && pport == 0);
        chk("m_i1_rvalid", i1_rvalid, pend && pport == 1);
        chk("m_i0_rdata", i0_read_data, (pend && pport == 0) ? pdata : 0);
        chk("m_i1_rdata", i1_read_data, (pend && pport == 1) ? pdata : 0);
        if (r == 2'b11 && scf < 16'hFFFF) scf++;
        if (g == 0 && sc0 < 16'hFFFF) sc0++;
        if (g == 1 && sc1 < 16'hFFFF) sc1++;
        pend = 0;
        if (g >= 0) begin
          last = g;
          if (g_lock) begin
            cnt   = (owner == g) ? ((cnt + 1 > LOCK_MAX) ? LOCK_MAX : cnt + 1) : 1;
            owner = g;
          end else begin
            owner = -1; cnt = 0;
          end
          h_addr = g_addr; h_be = g_be; h_wd = g_wd;
          if (g_we) begin
            for (int b = 0; b < BW; b++)
              if (g_be[b]) mmem[g_addr][8*b +: 8] = g_wd[8*b +: 8];
          end else begin
            pend = 1; pport = g; pdata = mmem[g_addr];
          end
        end else begin
          owner = -1; cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  // Single-initiator access; reports cycles waited before the grant
  task automatic access(input int port, input logic we, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd, output int waited);
    logic granted;
    granted = 1'b0;
    waited  = 0;
    if (port == 0) begin
      i0_req = 1; i0_write_en = we; i0_addr = a; i0_byte_en = be; i0_write_data = wd;
    end else begin
      i1_req = 1; i1_write_en = we; i1_addr = a; i1_byte_en = be; i1_write_data = wd;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((port == 0) ? i0_gnt : i1_gnt) begin granted = 1'b1; break; end
      waited++;
    end
    chk("access_granted", granted, 1'b1);
    tick();
    i0_req = 0; i1_req = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w;
    // Reset state
    @(negedge clk);
    chk("reset_gnt", {i0_gnt, i1_gnt}, 2'b00);
    chk("reset_addr", addr, 0);
    tick();
    rst_n = 1'b1;

    // Single-port write then read
    access(0, 1, 10'd5, 4'hF, 32'hDEADBEEF, w); chk("sp_write_lat", 64'(w), 0);
    access(0, 0, 10'd5, 4'hF, 32'h0, w);        chk("sp_read_lat", 64'(w), 0);
    @(negedge clk);
    chk("sp_rvalid0", i0_rvalid, 1'b1);
    chk("sp_rdata0", i0_read_data, 32'hDEADBEEF);
    chk("sp_rvalid1", i1_rvalid, 1'b0);
    tick();

    // Byte-enable merge
    access(0, 1, 10'd0, 4'hF, 32'h11223344, w);
    access(1, 1, 10'd0, 4'b0101, 32'hAABBCCDD, w);
    access(1, 0, 10'd0, 4'hF, 32'h0, w);
    @(negedge clk);
    chk("be_rvalid1", i1_rvalid, 1'b1);
    chk("be_rdata1", i1_read_data, 32'h11BB33DD);
    tick();

    // Idle cycle holds last payload, strobes low
    access(0, 1, 10'd7, 4'h3, 32'h00001234, w);
    @(negedge clk);
    chk("hold_addr", addr, 10'd7);
    chk("hold_be", byte_en, 4'h3);
    chk("hold_strobes", {read_en, write_en}, 2'b00);
    tick();

    // Preload for alternation
    for (int i = 0; i < 4; i++) begin
      access(0, 1, 10'(16 + i), 4'hF, 32'hA0000000 + 32'(i), w);
      access(1, 1, 10'(32 + i), 4'hF, 32'hB0000000 + 32'(i), w);
    end

    // Round-robin alternation of back-to-back reads
    do_reset();
    begin
      int p0, p1;
      logic g0, g1;
      p0 = 0; p1 = 0;
      i0_req = 1; i0_write_en = 0; i0_lock = 0; i0_addr = 10'd16;
      i1_req = 1; i1_write_en = 0; i1_lock = 0; i1_addr = 10'd32;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        chk("alt_gnt0", i0_gnt, (c % 2) == 0);
        chk("alt_gnt1", i1_gnt, (c % 2) == 1);
        if (c % 2 == 1)
          chk("alt_rdata0", i0_read_data, 32'hA0000000 + 32'((c - 1) / 2));
        else if (c > 0)
          chk("alt_rdata1", i1_read_data, 32'hB0000000 + 32'((c - 2) / 2));
        g0 = i0_gnt; g1 = i1_gnt;
        tick();
        if (g0) begin p0++; i0_addr = 10'(16 + p0); end
        if (g1) begin p1++; i1_addr = 10'(32 + p1); end
      end
      i0_req = 0; i1_req = 0;
    end
    tick();

    // Bounded lock: 16 grants to port 0, one to port 1, then port 0 again
    do_reset();
    i0_req = 1; i0_lock = 1; i0_write_en = 0; i0_addr = 10'd16;
    i1_req = 1; i1_lock = 0; i1_write_en = 0; i1_addr = 10'd32;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("lock_gnt0", i0_gnt, c != 16);
      chk("lock_gnt1", i1_gnt, c == 16);
      tick();
    end
    i0_req = 0; i0_lock = 0; i1_req = 0;
    tick();

    // Reset right after an i1 read grant drops the return
    i1_req = 1; i1_write_en = 0; i1_addr = 10'd33;
    @(negedge clk);
    chk("mid_gnt1", i1_gnt, 1'b1);
    tick();
    i1_req = 0; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rvalid1", i1_rvalid, 1'b0);
    tick();
    @(negedge clk);
    chk("mid_rvalid1_b", i1_rvalid, 1'b0);
    tick();
    rst_n = 1'b1;
    i0_req = 1; i0_write_en = 0; i0_addr = 10'd16;
    i1_req = 1; i1_write_en = 0; i1_addr = 10'd32;
    @(negedge clk);
    chk("post_rst_tie", {i0_gnt, i1_gnt}, 2'b10);
    tick();
    i0_req = 0; i1_req = 0;
    tick();

`ifdef GENERIC_SRAM_ARB_STATS_EN
    // Statistics counters over 10 contended cycles
    do_reset();
    i0_req = 1; i0_lock = 0; i1_req = 1; i1_lock = 0;
    for (int c = 0; c < 10; c++) tick();
    i0_req = 0; i1_req = 0;
    @(negedge clk);
    chk("stats_i0", i0_gnt_count, 16'd5);
    chk("stats_i1", i1_gnt_count, 16'd5);
    chk("stats_conflict", conflict_count, 16'd10);
    tick();
`endif

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
